// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register specifiers, write-back FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] IHALT    = 4'h0;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] IRRMOVQ  = 4'h2;
    localparam logic [3:0] IIRMOVQ  = 4'h3;
    localparam logic [3:0] IRMMOVQ  = 4'h4;
    localparam logic [3:0] IMRMOVQ  = 4'h5;
    localparam logic [3:0] IOPQ     = 4'h6;
    localparam logic [3:0] IJXX     = 4'h7;
    localparam logic [3:0] ICALL    = 4'h8;
    localparam logic [3:0] IRET     = 4'h9;
    localparam logic [3:0] IPUSHQ   = 4'hA;
    localparam logic [3:0] IPOPQ    = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2
    } wb_state_t;

endpackage

// File: rtl/y86_dst_decode.sv
// Maps icode/cnd/rA/rB to the E and M destination registers plus an illegal flag.
// Latency: purely combinational.
// Backpressure: none; shared with the hazard unit.
module y86_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m,
    output logic       illegal
);

    // Destination table; conditional moves only write when the condition held.
    always_comb begin
        dst_e   = REG_NONE;
        dst_m   = REG_NONE;
        illegal = 1'b0;
        case (icode)
            IHALT, INOP, IRMMOVQ, IJXX: begin
                dst_e = REG_NONE;
                dst_m = REG_NONE;
            end
            IRRMOVQ: begin
                dst_e = cnd ? rB : REG_NONE;
            end
            IIRMOVQ, IOPQ: begin
                dst_e = rB;
            end
            IMRMOVQ: begin
                dst_m = rA;
            end
            ICALL, IRET, IPUSHQ: begin
                dst_e = REG_RSP;
            end
            IPOPQ: begin
                dst_e = REG_RSP;
                dst_m = rA;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/y86_wb_sequencer.sv
// Serialises each retiring instruction's E/M register writes onto the single write port.
// Latency: first write registered one cycle after accept, second write the cycle after.
// Backpressure: wb_ready drops while an M write is still queued behind an E write, and forever after halt.
module y86_wb_sequencer
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    wb_state_t         state_q, state_nxt;
    logic [3:0]        m_dst_q, m_dst_nxt;
    logic [DATA_W-1:0] m_val_q, m_val_nxt;
    logic              wr_en_nxt;
    logic [3:0]        wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_nxt;

    logic [3:0]        dec_e;
    logic [3:0]        dec_m;
    logic              dec_ill;
    logic              e_need;
    logic              m_need;
    logic              m_pend;
    logic              accept;

    y86_dst_decode u_dec (
        .icode   (icode),
        .cnd     (cnd),
        .rA      (rA),
        .rB      (rB),
        .dst_e   (dec_e),
        .dst_m   (dec_m),
        .illegal (dec_ill)
    );

    // Write needs for the presented instruction; a shared E/M destination keeps only valM.
    always_comb begin
        m_need   = (dec_m != REG_NONE);
        e_need   = (dec_e != REG_NONE) && (dec_e != dec_m);
        m_pend   = (m_dst_q != REG_NONE);
        wb_ready = !halted && ((state_q == IDLE) || (state_q == WR_M) ||
                               ((state_q == WR_E) && !m_pend));
        accept   = wb_valid && wb_ready;
    end

    // Next state and next write-port contents; the state names the write being driven.
    always_comb begin
        state_nxt   = IDLE;
        m_dst_nxt   = m_dst_q;
        m_val_nxt   = m_val_q;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = REG_NONE;
        wr_data_nxt = '0;
        if (state_q == WR_E && m_pend) begin
            state_nxt   = WR_M;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = m_dst_q;
            wr_data_nxt = m_val_q;
            m_dst_nxt   = REG_NONE;
        end else if (accept) begin
            m_val_nxt = valM;
            if (e_need) begin
                state_nxt   = WR_E;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = dec_e;
                wr_data_nxt = valE;
                m_dst_nxt   = dec_m;
            end else if (m_need) begin
                state_nxt   = WR_M;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = dec_m;
                wr_data_nxt = valM;
                m_dst_nxt   = REG_NONE;
            end else begin
                state_nxt   = IDLE;
                m_dst_nxt   = REG_NONE;
            end
        end
    end

    // FSM, queued M write and registered write port; reset drops any pending write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_dst_q <= REG_NONE;
            m_val_q <= '0;
            wr_en   <= 1'b0;
            wr_addr <= REG_NONE;
            wr_data <= '0;
        end else begin
            state_q <= state_nxt;
            m_dst_q <= m_dst_nxt;
            m_val_q <= m_val_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
        end
    end

    // Sticky status flags and retired-instruction counter, all stepped on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else if (accept) begin
            retired <= retired + 1'b1;
            if (icode == IHALT) halted  <= 1'b1;
            if (dec_ill)        illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_y86_wb_sequencer.sv
// Directed bench for the write-back sequencer with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised through popq and a held wb_valid across busy cycles.
module tb_y86_wb_sequencer;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wb_valid = 1'b0;
    logic              wb_ready;
    logic [3:0]        icode = 4'h1;
    logic              cnd = 1'b0;
    logic [3:0]        rA = 4'hF;
    logic [3:0]        rB = 4'hF;
    logic [DATA_W-1:0] valE = '0;
    logic [DATA_W-1:0] valM = '0;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  retired;

    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] exp_retired = '0;

    y86_wb_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .icode    (icode),
        .cnd      (cnd),
        .rA       (rA),
        .rB       (rB),
        .valE     (valE),
        .valM     (valM),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic present(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [DATA_W-1:0] ve,
                           input logic [DATA_W-1:0] vm);
        wb_valid = 1'b1;
        icode = ic; cnd = c; rA = ra; rB = rb; valE = ve; valM = vm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wb_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_retired = '0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
        n_checks++; if (wr_addr !== 4'hF) begin n_errors++; $display("FAIL reset_wr_addr got %0h want f", wr_addr); end
        n_checks++; if (wr_data !== 64'h0) begin n_errors++; $display("FAIL reset_wr_data got %0h want 0", wr_data); end
        n_checks++; if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %0b want 1", wb_ready); end
        n_checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_errors++; $display("FAIL reset_flags got h=%0b i=%0b want 0 0", halted, illegal); end
        n_checks++; if (retired !== 32'd0) begin n_errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    endtask

    task automatic test_irmovq();
        present(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'h0);
        step(); wb_valid = 1'b0; exp_retired++;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h2 || wr_data !== 64'h1234) begin n_errors++; $display("FAIL irmovq_write got en=%0b a=%0h d=%0h want 1 2 1234", wr_en, wr_addr, wr_data); end
        n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL irmovq_retired got %0d want %0d", retired, exp_retired); end
        n_checks++; if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL irmovq_ready got %0b want 1", wb_ready); end
        step();
        n_checks++; if (wr_en !== 1'b0 || wr_addr !== 4'hF) begin n_errors++; $display("FAIL irmovq_idle got en=%0b a=%0h want 0 f", wr_en, wr_addr); end
    endtask

    task automatic test_popq();
        present(4'hB, 1'b0, 4'h3, 4'hF, 64'h100, 64'hAB);
        step(); wb_valid = 1'b0; exp_retired++;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h4 || wr_data !== 64'h100) begin n_errors++; $display("FAIL popq_e_write got en=%0b a=%0h d=%0h want 1 4 100", wr_en, wr_addr, wr_data); end
        n_checks++; if (wb_ready !== 1'b0) begin n_errors++; $display("FAIL popq_ready_busy got %0b want 0", wb_ready); end
        step();
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h3 || wr_data !== 64'hAB) begin n_errors++; $display("FAIL popq_m_write got en=%0b a=%0h d=%0h want 1 3 ab", wr_en, wr_addr, wr_data); end
        n_checks++; if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL popq_ready_free got %0b want 1", wb_ready); end
        step();
        n_checks++; if (wr_en !== 1'b0 || wr_addr !== 4'hF) begin n_errors++; $display("FAIL popq_idle got en=%0b a=%0h want 0 f", wr_en, wr_addr); end
    endtask

    task automatic test_popq_rsp();
        present(4'hB, 1'b0, 4'h4, 4'hF, 64'h99, 64'h55);
        step(); wb_valid = 1'b0; exp_retired++;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h4 || wr_data !== 64'h55) begin n_errors++; $display("FAIL popq_rsp_write got en=%0b a=%0h d=%0h want 1 4 55", wr_en, wr_addr, wr_data); end
        n_checks++; if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL popq_rsp_ready got %0b want 1", wb_ready); end
        step();
        n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL popq_rsp_single got en=%0b a=%0h d=%0h want 0", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_cmov();
        present(4'h2, 1'b0, 4'h1, 4'h5, 64'h9, 64'h0);
        step(); exp_retired++;
        n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL cmov_nc got en=%0b a=%0h want 0", wr_en, wr_addr); end
        present(4'h2, 1'b1, 4'h1, 4'h5, 64'h7, 64'h0);
        step(); wb_valid = 1'b0; exp_retired++;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h5 || wr_data !== 64'h7) begin n_errors++; $display("FAIL cmov_c got en=%0b a=%0h d=%0h want 1 5 7", wr_en, wr_addr, wr_data); end
        n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL cmov_retired got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_back_to_back();
        // popq then irmovq held on wb_valid while the sequencer is busy.
        present(4'hB, 1'b0, 4'h7, 4'hF, 64'h200, 64'hCD);
        step(); exp_retired++;
        present(4'h3, 1'b0, 4'hF, 4'h6, 64'h77, 64'hEE);
        n_checks++; if (wr_addr !== 4'h4 || wr_data !== 64'h200 || wb_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_e got a=%0h d=%0h rdy=%0b want 4 200 0", wr_addr, wr_data, wb_ready); end
        step();
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h7 || wr_data !== 64'hCD) begin n_errors++; $display("FAIL b2b_m got en=%0b a=%0h d=%0h want 1 7 cd", wr_en, wr_addr, wr_data); end
        n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL b2b_hold_retired got %0d want %0d", retired, exp_retired); end
        step(); wb_valid = 1'b0; exp_retired++;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h6 || wr_data !== 64'h77) begin n_errors++; $display("FAIL b2b_next got en=%0b a=%0h d=%0h want 1 6 77", wr_en, wr_addr, wr_data); end
        n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL b2b_retired got %0d want %0d", retired, exp_retired); end
        step();
    endtask

    task automatic test_status();
        do_reset();
        present(4'h1, 1'b0, 4'hF, 4'hF, 64'h11, 64'h22);
        step();
        n_checks++; if (wr_en !== 1'b0 || illegal !== 1'b0) begin n_errors++; $display("FAIL nop got en=%0b ill=%0b want 0 0", wr_en, illegal); end
        present(4'h4, 1'b0, 4'h1, 4'h2, 64'h33, 64'h44);
        step();
        n_checks++; if (wr_en !== 1'b0 || illegal !== 1'b0) begin n_errors++; $display("FAIL rmmovq got en=%0b ill=%0b want 0 0", wr_en, illegal); end
        present(4'hC, 1'b1, 4'h1, 4'h2, 64'h55, 64'h66);
        step();
        n_checks++; if (wr_en !== 1'b0 || illegal !== 1'b1 || halted !== 1'b0) begin n_errors++; $display("FAIL illegal got en=%0b ill=%0b h=%0b want 0 1 0", wr_en, illegal, halted); end
        present(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        n_checks++; if (wr_en !== 1'b0 || halted !== 1'b1 || wb_ready !== 1'b0) begin n_errors++; $display("FAIL halt got en=%0b h=%0b rdy=%0b want 0 1 0", wr_en, halted, wb_ready); end
        n_checks++; if (retired !== 32'd4) begin n_errors++; $display("FAIL halt_retired got %0d want 4", retired); end
        present(4'h3, 1'b0, 4'hF, 4'h2, 64'h88, 64'h0);
        step(); step(); step();
        wb_valid = 1'b0;
        n_checks++; if (wr_en !== 1'b0 || retired !== 32'd4 || wb_ready !== 1'b0 || illegal !== 1'b1) begin n_errors++; $display("FAIL halt_sticky got en=%0b ret=%0d rdy=%0b ill=%0b want 0 4 0 1", wr_en, retired, wb_ready, illegal); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        present(4'hB, 1'b0, 4'h3, 4'hF, 64'h100, 64'hAB);
        step(); wb_valid = 1'b0;
        n_checks++; if (wr_en !== 1'b1 || retired !== 32'd1) begin n_errors++; $display("FAIL mid_first got en=%0b ret=%0d want 1 1", wr_en, retired); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (wr_en !== 1'b0 || wr_addr !== 4'hF || retired !== 32'd0) begin n_errors++; $display("FAIL mid_async got en=%0b a=%0h ret=%0d want 0 f 0", wr_en, wr_addr, retired); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (wr_en !== 1'b0 || wr_addr !== 4'hF) begin n_errors++; $display("FAIL mid_no_m got en=%0b a=%0h want 0 f", wr_en, wr_addr); end
        n_checks++; if (wb_ready !== 1'b1 || retired !== 32'd0 || halted !== 1'b0) begin n_errors++; $display("FAIL mid_release got rdy=%0b ret=%0d h=%0b want 1 0 0", wb_ready, retired, halted); end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_popq();
        test_popq_rsp();
        test_cmov();
        test_back_to_back();
        test_status();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
